// File: rtl/hazard_stall_unit.sv
// Decode-side hazard controller: load-use detection, shared multi-cycle FP unit
// sequencing, branch flush priority and a saturating stall-cycle counter.
module hazard_stall_unit #(
    parameter int unsigned REG_AW  = 4,
    parameter int unsigned FP_LAT  = 4,
    parameter bit          R0_ZERO = 1'b1,
    parameter int unsigned CNT_W   = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic              id_use_rs1,
    input  logic              id_use_rs2,
    input  logic              id_pf_op,
    input  logic              ex_valid,
    input  logic              ex_mem_read,
    input  logic              ex_reg_write,
    input  logic [REG_AW-1:0] ex_rd,
    input  logic              ex_branch_taken,
    input  logic              perf_clr,
    output logic              stall,
    output logic              bubble_id_ex,
    output logic              flush_if_id,
    output logic              pf_issue,
    output logic              pf_busy,
    output logic              pf_wb_valid,
    output logic [CNT_W-1:0]  stall_cycles
);

    localparam int unsigned      CW         = (FP_LAT > 2) ? $clog2(FP_LAT) : 1;
    localparam logic [CW-1:0]    CNT_RELOAD = CW'(FP_LAT - 1);
    localparam logic [CNT_W-1:0] STALL_MAX  = '1;

    typedef enum logic {IDLE, BUSY} state_e;

    state_e           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [CNT_W-1:0] stall_cycles_q, stall_cycles_d;

    logic load_use;
    logic pf_hold;
    logic stall_c;
    logic pf_issue_c;
    logic pf_wb_c;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= IDLE;
            cnt_q          <= '0;
            stall_cycles_q <= '0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            stall_cycles_q <= stall_cycles_d;
        end
    end

    // Hazard decode, FP sequencer next state and counter update
    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        stall_cycles_d = stall_cycles_q;

        load_use = id_valid && ex_valid && ex_mem_read && ex_reg_write &&
                   ((id_use_rs1 && (id_rs1 == ex_rd)) ||
                    (id_use_rs2 && (id_rs2 == ex_rd)));
        if (R0_ZERO && (ex_rd == '0)) begin
            load_use = 1'b0;
        end

        pf_hold    = id_valid && (state_q == BUSY) && (cnt_q != '0);
        stall_c    = (load_use || pf_hold) && !ex_branch_taken;
        pf_issue_c = id_valid && id_pf_op && !stall_c && !ex_branch_taken &&
                     ((state_q == IDLE) || (cnt_q == '0));
        pf_wb_c    = (state_q == BUSY) && (cnt_q == '0);

        // In-flight op always drains; a branch only affects the ID instruction
        case (state_q)
            IDLE: begin
                if (pf_issue_c) begin
                    state_d = BUSY;
                    cnt_d   = CNT_RELOAD;
                end
            end
            BUSY: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CW'(1);
                end else if (pf_issue_c) begin
                    cnt_d = CNT_RELOAD;
                end else begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase

        if (perf_clr) begin
            stall_cycles_d = '0;
        end else if (stall_c && (stall_cycles_q != STALL_MAX)) begin
            stall_cycles_d = stall_cycles_q + CNT_W'(1);
        end
    end

    // Outputs are forced low for the whole reset window
    assign stall        = !rst && stall_c;
    assign bubble_id_ex = !rst && (stall_c || ex_branch_taken);
    assign flush_if_id  = !rst && ex_branch_taken;
    assign pf_issue     = !rst && pf_issue_c;
    assign pf_busy      = !rst && (state_q == BUSY);
    assign pf_wb_valid  = !rst && pf_wb_c;
    assign stall_cycles = rst ? '0 : stall_cycles_q;

endmodule

// File: tb/tb_hazard_stall_unit.sv
// Bench for hazard_stall_unit: timestamp-based reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_hazard_stall_unit;

    logic       clk = 1'b0;
    logic       rst;
    logic       id_valid, id_use_rs1, id_use_rs2, id_pf_op;
    logic [3:0] id_rs1, id_rs2, ex_rd;
    logic       ex_valid, ex_mem_read, ex_reg_write, ex_branch_taken, perf_clr;

    logic        stall, bubble_id_ex, flush_if_id, pf_issue, pf_busy, pf_wb_valid;
    logic [15:0] stall_cycles;
    logic        s2_stall, s2_bubble, s2_flush, s2_issue, s2_busy, s2_wb;
    logic [3:0]  s2_cycles;

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference model: FP op tracked by the absolute cycle its result is due
    bit inflight = 1'b0;
    int done_cyc = 0;
    int cyc      = 0;
    int sc_a     = 0;
    int sc_b     = 0;

    always #5 clk = ~clk;

    hazard_stall_unit u_dut (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .id_pf_op(id_pf_op),
        .ex_valid(ex_valid), .ex_mem_read(ex_mem_read), .ex_reg_write(ex_reg_write),
        .ex_rd(ex_rd), .ex_branch_taken(ex_branch_taken), .perf_clr(perf_clr),
        .stall(stall), .bubble_id_ex(bubble_id_ex), .flush_if_id(flush_if_id),
        .pf_issue(pf_issue), .pf_busy(pf_busy), .pf_wb_valid(pf_wb_valid),
        .stall_cycles(stall_cycles)
    );

    hazard_stall_unit #(.CNT_W(4)) u_dut4 (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .id_pf_op(id_pf_op),
        .ex_valid(ex_valid), .ex_mem_read(ex_mem_read), .ex_reg_write(ex_reg_write),
        .ex_rd(ex_rd), .ex_branch_taken(ex_branch_taken), .perf_clr(perf_clr),
        .stall(s2_stall), .bubble_id_ex(s2_bubble), .flush_if_id(s2_flush),
        .pf_issue(s2_issue), .pf_busy(s2_busy), .pf_wb_valid(s2_wb),
        .stall_cycles(s2_cycles)
    );

    function automatic void chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endfunction

    task automatic idle_inputs();
        rst = 1'b0; id_valid = 1'b0; id_use_rs1 = 1'b0; id_use_rs2 = 1'b0; id_pf_op = 1'b0;
        id_rs1 = 4'd0; id_rs2 = 4'd0; ex_rd = 4'd0; ex_valid = 1'b0; ex_mem_read = 1'b0;
        ex_reg_write = 1'b0; ex_branch_taken = 1'b0; perf_clr = 1'b0;
    endtask

    task automatic set_load_use(input logic [3:0] rd);
        ex_valid = 1'b1; ex_mem_read = 1'b1; ex_reg_write = 1'b1; ex_rd = rd;
        id_valid = 1'b1; id_use_rs2 = 1'b1; id_rs2 = rd;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Compare both instances against the model on the falling edge, then advance the model
    task automatic eval();
        bit lu, hold, e_stall, e_issue, e_wb, e_busy, e_flush, e_bub;
        int e_ca, e_cb;
        @(negedge clk);
        lu = id_valid && ex_valid && ex_mem_read && ex_reg_write && (ex_rd != 0) &&
             ((id_use_rs1 && id_rs1 == ex_rd) || (id_use_rs2 && id_rs2 == ex_rd));
        hold    = id_valid && inflight && (cyc < done_cyc);
        e_stall = (lu || hold) && !ex_branch_taken;
        e_issue = id_valid && id_pf_op && !e_stall && !ex_branch_taken &&
                  (!inflight || cyc == done_cyc);
        e_wb    = inflight && (cyc == done_cyc);
        e_busy  = inflight;
        e_flush = ex_branch_taken;
        e_bub   = e_stall || ex_branch_taken;
        e_ca    = sc_a;
        e_cb    = sc_b;
        if (rst) begin
            e_stall = 0; e_issue = 0; e_wb = 0; e_busy = 0; e_flush = 0; e_bub = 0;
            e_ca = 0; e_cb = 0;
        end
        chk("stall", int'(stall), int'(e_stall));
        chk("bubble_id_ex", int'(bubble_id_ex), int'(e_bub));
        chk("flush_if_id", int'(flush_if_id), int'(e_flush));
        chk("pf_issue", int'(pf_issue), int'(e_issue));
        chk("pf_busy", int'(pf_busy), int'(e_busy));
        chk("pf_wb_valid", int'(pf_wb_valid), int'(e_wb));
        chk("stall_cycles", int'(stall_cycles), e_ca);
        chk("w4_stall", int'(s2_stall), int'(e_stall));
        chk("w4_bubble", int'(s2_bubble), int'(e_bub));
        chk("w4_flush", int'(s2_flush), int'(e_flush));
        chk("w4_issue", int'(s2_issue), int'(e_issue));
        chk("w4_busy", int'(s2_busy), int'(e_busy));
        chk("w4_wb", int'(s2_wb), int'(e_wb));
        chk("w4_stall_cycles", int'(s2_cycles), e_cb);
        if (rst) begin
            inflight = 1'b0; sc_a = 0; sc_b = 0;
        end else begin
            if (e_issue) begin
                inflight = 1'b1;
                done_cyc = cyc + 4;
            end else if (inflight && cyc == done_cyc) begin
                inflight = 1'b0;
            end
            if (perf_clr) begin
                sc_a = 0; sc_b = 0;
            end else if (e_stall) begin
                if (sc_a < 65535) sc_a++;
                if (sc_b < 15) sc_b++;
            end
        end
        cyc++;
    endtask

    task automatic clear_counter();
        idle_inputs();
        perf_clr = 1'b1;
        eval();
        tick();
        perf_clr = 1'b0;
    endtask

    initial begin
        idle_inputs();
        rst = 1'b1;
        eval();
        chk("lit_reset_stall", int'(stall), 0);
        chk("lit_reset_cycles", int'(stall_cycles), 0);
        tick();
        eval();
        tick();

        // Load-use on r3, then release, then the r0 exemption
        idle_inputs();
        set_load_use(4'd3);
        eval();
        chk("lit_lu_stall", int'(stall), 1);
        chk("lit_lu_bubble", int'(bubble_id_ex), 1);
        tick();
        ex_valid = 1'b0;
        eval();
        chk("lit_lu_release", int'(stall), 0);
        chk("lit_lu_count", int'(stall_cycles), 1);
        tick();
        set_load_use(4'd0);
        eval();
        chk("lit_r0_nostall", int'(stall), 0);
        tick();

        // Single FP op with a plain instruction waiting behind it
        clear_counter();
        for (int c = 0; c <= 5; c++) begin
            id_valid = 1'b1;
            id_pf_op = (c == 0);
            eval();
            chk("lit_fp_issue", int'(pf_issue), int'(c == 0));
            chk("lit_fp_stall", int'(stall), int'(c >= 1 && c <= 3));
            chk("lit_fp_wb", int'(pf_wb_valid), int'(c == 4));
            if (c == 5) begin
                chk("lit_fp_busy_end", int'(pf_busy), 0);
                chk("lit_fp_count", int'(stall_cycles), 3);
            end
            tick();
        end

        // Back-to-back FP ops
        clear_counter();
        for (int c = 0; c <= 9; c++) begin
            id_valid = 1'b1;
            id_pf_op = (c <= 4);
            eval();
            chk("lit_b2b_issue", int'(pf_issue), int'(c == 0 || c == 4));
            chk("lit_b2b_wb", int'(pf_wb_valid), int'(c == 4 || c == 8));
            chk("lit_b2b_busy", int'(pf_busy), int'(c >= 1 && c <= 8));
            tick();
        end

        // Branch beats load-use and an FP issue
        clear_counter();
        set_load_use(4'd5);
        id_pf_op = 1'b1;
        ex_branch_taken = 1'b1;
        eval();
        chk("lit_br_stall", int'(stall), 0);
        chk("lit_br_flush", int'(flush_if_id), 1);
        chk("lit_br_bubble", int'(bubble_id_ex), 1);
        chk("lit_br_issue", int'(pf_issue), 0);
        tick();
        idle_inputs();
        eval();
        chk("lit_br_count", int'(stall_cycles), 0);
        tick();

        // Branch while the FP unit is busy with two cycles remaining
        for (int c = 0; c <= 4; c++) begin
            idle_inputs();
            id_valid = (c <= 2);
            id_pf_op = (c == 0);
            ex_branch_taken = (c == 2);
            eval();
            if (c == 2) chk("lit_brbusy_stall", int'(stall), 0);
            chk("lit_brbusy_wb", int'(pf_wb_valid), int'(c == 4));
            tick();
        end

        // Reset in the middle of an FP op
        clear_counter();
        for (int c = 0; c <= 4; c++) begin
            idle_inputs();
            id_valid = (c != 2);
            id_pf_op = (c == 0);
            rst = (c == 2);
            eval();
            if (c == 2) chk("lit_rst_outputs", int'(stall | pf_busy | pf_issue), 0);
            if (c == 3) begin
                chk("lit_rst_busy", int'(pf_busy), 0);
                chk("lit_rst_stall", int'(stall), 0);
                chk("lit_rst_count", int'(stall_cycles), 0);
            end
            if (c == 4) chk("lit_rst_no_wb", int'(pf_wb_valid), 0);
            tick();
        end

        // Saturation of the 4-bit counter and perf_clr priority
        clear_counter();
        for (int c = 0; c < 20; c++) begin
            idle_inputs();
            set_load_use(4'd7);
            eval();
            tick();
        end
        perf_clr = 1'b1;
        eval();
        chk("lit_sat_w4", int'(s2_cycles), 15);
        chk("lit_sat_w16", int'(stall_cycles), 20);
        chk("lit_clr_stall", int'(stall), 1);
        tick();
        idle_inputs();
        eval();
        chk("lit_clr_w4", int'(s2_cycles), 0);
        chk("lit_clr_w16", int'(stall_cycles), 0);
        tick();

        // Randomized traffic
        for (int c = 0; c < 800; c++) begin
            rst             = ($urandom_range(63) == 0);
            perf_clr        = ($urandom_range(31) == 0);
            id_valid        = ($urandom_range(3) != 0);
            id_pf_op        = ($urandom_range(2) == 0);
            id_use_rs1      = $urandom_range(1);
            id_use_rs2      = $urandom_range(1);
            id_rs1          = 4'($urandom_range(3));
            id_rs2          = 4'($urandom_range(3));
            ex_rd           = 4'($urandom_range(3));
            ex_valid        = $urandom_range(1);
            ex_mem_read     = $urandom_range(1);
            ex_reg_write    = ($urandom_range(3) != 0);
            ex_branch_taken = ($urandom_range(7) == 0);
            eval();
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $finish;
    end

endmodule
